// File: rtl/mem_access_unit.sv
// Load/store sequencer in front of the data memory of the multi-cycle MIPS datapath.
// It takes one request from the control FSM and computes the effective address.
// It checks the opcode, alignment and address range, then drives a single DMEM access cycle.
// Load data is captured into the MDR, and completion or fault is reported back.
// Every output is a register, so the async reset drops all strobes at once.
module mem_access_unit #(
  parameter int ADDR_W = 7,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [2:0]        op,
  input  logic              is_store,
  input  logic [31:0]       base,
  input  logic [15:0]       offset,
  input  logic [DATA_W-1:0] store_data,
  input  logic [DATA_W-1:0] dmem_rdata,
  output logic              dmem_write,
  output logic              dmem_read,
  output logic [ADDR_W-1:0] dmem_addr,
  output logic [DATA_W-1:0] dmem_wdata,
  output logic              dmem_is_byte,
  output logic              dmem_is_half,
  output logic              dmem_is_signed,
  output logic [DATA_W-1:0] mdr,
  output logic              busy,
  output logic              done,
  output logic              fault,
  output logic [1:0]        fault_code,
  output logic [31:0]       bad_vaddr
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    CALC   = 3'd1,
    ACCESS = 3'd2,
    DONE   = 3'd3,
    FAULT  = 3'd4
  } state_t;

  state_t              state_r, next_state_s;
  logic [31:0]         ea_r;
  logic [2:0]          op_r;
  logic                is_store_r;
  logic [DATA_W-1:0]   store_data_r;
  logic [DATA_W-1:0]   mdr_r;
  logic [31:0]         bad_vaddr_r;
  logic [1:0]          fault_code_r;
  logic [1:0]          chk_s;
  logic                acc_next_s;
  logic                dmem_write_r, dmem_read_r;
  logic [ADDR_W-1:0]   dmem_addr_r;
  logic [DATA_W-1:0]   dmem_wdata_r;
  logic                is_byte_r, is_half_r, is_signed_r;
  logic                busy_r, done_r, fault_r;

  // Request check.
  // The first failing check wins: illegal op (11), then misaligned (01), then out of range (10).
  // A result of 00 means the request is valid.
  function automatic logic [1:0] check_req(input logic [31:0] ea, input logic [2:0] opc,
                                           input logic st);
    logic ill, mis, oor;
    ill = (opc == 3'b010) || (opc == 3'b110) || (opc == 3'b111) || (st && opc[2]);
    mis = ((opc[1:0] == 2'b01) && ea[0]) || ((opc[1:0] == 2'b11) && (ea[1:0] != 2'b00));
    oor = (ea[31:ADDR_W] != {(32-ADDR_W){1'b0}});
    if (ill) begin
      return 2'b11;
    end else if (mis) begin
      return 2'b01;
    end else if (oor) begin
      return 2'b10;
    end else begin
      return 2'b00;
    end
  endfunction

  // Next-state decode and request check
  always_comb begin
    next_state_s = state_r;
    chk_s        = check_req(ea_r, op_r, is_store_r);
    acc_next_s   = 1'b0;
    case (state_r)
      IDLE: begin
        if (start) next_state_s = CALC;
        else       next_state_s = IDLE;
      end
      CALC: begin
        if (chk_s != 2'b00) next_state_s = FAULT;
        else                next_state_s = ACCESS;
      end
      ACCESS:  next_state_s = DONE;
      DONE:    next_state_s = IDLE;
      FAULT:   next_state_s = IDLE;
      default: next_state_s = IDLE;
    endcase
    acc_next_s = (next_state_s == ACCESS);
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_r <= IDLE;
    else     state_r <= next_state_s;
  end

  // Latch the request when it is accepted in IDLE.
  // The effective address wraps modulo 2^32.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ea_r         <= 32'd0;
      op_r         <= 3'd0;
      is_store_r   <= 1'b0;
      store_data_r <= {DATA_W{1'b0}};
    end else if ((state_r == IDLE) && start) begin
      ea_r         <= base + {{16{offset[15]}}, offset};
      op_r         <= op;
      is_store_r   <= is_store;
      store_data_r <= store_data;
    end
  end

  // Capture load data into the MDR, and latch fault code and address when a request is rejected
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mdr_r        <= {DATA_W{1'b0}};
      fault_code_r <= 2'b00;
      bad_vaddr_r  <= 32'd0;
    end else begin
      if ((state_r == ACCESS) && !is_store_r) mdr_r <= dmem_rdata;
      if ((state_r == CALC) && (chk_s != 2'b00)) begin
        fault_code_r <= chk_s;
        bad_vaddr_r  <= ea_r;
      end
    end
  end

  // Registered DMEM controls and status.
  // These are loaded from the next state, so they are valid during the state itself.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dmem_write_r <= 1'b0;
      dmem_read_r  <= 1'b0;
      dmem_addr_r  <= {ADDR_W{1'b0}};
      dmem_wdata_r <= {DATA_W{1'b0}};
      is_byte_r    <= 1'b0;
      is_half_r    <= 1'b0;
      is_signed_r  <= 1'b0;
      busy_r       <= 1'b0;
      done_r       <= 1'b0;
      fault_r      <= 1'b0;
    end else begin
      dmem_write_r <= acc_next_s & is_store_r;
      dmem_read_r  <= acc_next_s & ~is_store_r;
      dmem_addr_r  <= acc_next_s ? ea_r[ADDR_W-1:0] : {ADDR_W{1'b0}};
      dmem_wdata_r <= acc_next_s ? store_data_r : {DATA_W{1'b0}};
      is_byte_r    <= acc_next_s & (op_r[1:0] == 2'b00);
      is_half_r    <= acc_next_s & (op_r[1:0] == 2'b01);
      is_signed_r  <= acc_next_s & ~is_store_r & ~op_r[2];
      busy_r       <= (next_state_s != IDLE);
      done_r       <= (next_state_s == DONE);
      fault_r      <= (next_state_s == FAULT);
    end
  end

  assign dmem_write     = dmem_write_r;
  assign dmem_read      = dmem_read_r;
  assign dmem_addr      = dmem_addr_r;
  assign dmem_wdata     = dmem_wdata_r;
  assign dmem_is_byte   = is_byte_r;
  assign dmem_is_half   = is_half_r;
  assign dmem_is_signed = is_signed_r;
  assign mdr            = mdr_r;
  assign busy           = busy_r;
  assign done           = done_r;
  assign fault          = fault_r;
  assign fault_code     = fault_code_r;
  assign bad_vaddr      = bad_vaddr_r;

endmodule

// File: tb/tb_mem_access_unit.sv
// Testbench for mem_access_unit: byte-lane DMEM model plus a scoreboard of expected outcomes.
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [2:0]  op = 3'd0;
  logic        is_store = 1'b0;
  logic [31:0] base = 32'd0;
  logic [15:0] offset = 16'd0;
  logic [31:0] store_data = 32'd0;
  logic [31:0] dmem_rdata;
  logic        dmem_write, dmem_read, dmem_is_byte, dmem_is_half, dmem_is_signed;
  logic [6:0]  dmem_addr;
  logic [31:0] dmem_wdata, mdr, bad_vaddr;
  logic        busy, done, fault;
  logic [1:0]  fault_code;

  int compared = 0;
  int failed   = 0;

  typedef struct {
    logic st; logic [2:0] op; logic [31:0] base; logic [15:0] off; logic [31:0] data;
    logic restart; logic flt; logic [31:0] mdr; logic [1:0] code; logic [31:0] bad; logic sgn;
  } row_t;

  typedef struct {
    int n_write; int n_read; int n_done; int n_fault; int lat; int acc_c; int stray;
    logic [6:0] addr; logic [31:0] wdata; logic [1:0] size; logic sgn;
  } obs_t;

  row_t sb[$];

  mem_access_unit #(.ADDR_W(7), .DATA_W(32)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .is_store(is_store), .base(base),
    .offset(offset), .store_data(store_data), .dmem_rdata(dmem_rdata),
    .dmem_write(dmem_write), .dmem_read(dmem_read), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_is_byte(dmem_is_byte), .dmem_is_half(dmem_is_half),
    .dmem_is_signed(dmem_is_signed), .mdr(mdr), .busy(busy), .done(done), .fault(fault),
    .fault_code(fault_code), .bad_vaddr(bad_vaddr)
  );

  always #5 clk = ~clk;

  // Little-endian byte-lane DMEM model
  logic [7:0] mem [0:127];
  logic [6:0] a1, a2, a3;
  assign a1 = dmem_addr + 7'd1;
  assign a2 = dmem_addr + 7'd2;
  assign a3 = dmem_addr + 7'd3;

  always_comb begin
    dmem_rdata = {mem[a3], mem[a2], mem[a1], mem[dmem_addr]};
    if (dmem_is_byte)
      dmem_rdata = dmem_is_signed ? {{24{mem[dmem_addr][7]}}, mem[dmem_addr]}
                                  : {24'd0, mem[dmem_addr]};
    else if (dmem_is_half)
      dmem_rdata = dmem_is_signed ? {{16{mem[a1][7]}}, mem[a1], mem[dmem_addr]}
                                  : {16'd0, mem[a1], mem[dmem_addr]};
  end

  always @(posedge clk) begin
    if (dmem_write) begin
      mem[dmem_addr] <= dmem_wdata[7:0];
      if (!dmem_is_byte) mem[a1] <= dmem_wdata[15:8];
      if (!dmem_is_byte && !dmem_is_half) begin
        mem[a2] <= dmem_wdata[23:16];
        mem[a3] <= dmem_wdata[31:24];
      end
    end
  end

  function automatic row_t mk(logic st, logic [2:0] opc, logic [31:0] b, logic [15:0] o,
                              logic [31:0] d, logic rs, logic f, logic [31:0] m,
                              logic [1:0] c, logic [31:0] bv, logic s);
    row_t r;
    r.st = st; r.op = opc; r.base = b; r.off = o; r.data = d; r.restart = rs;
    r.flt = f; r.mdr = m; r.code = c; r.bad = bv; r.sgn = s;
    return r;
  endfunction

  function automatic logic [1:0] exp_size(logic [2:0] opc);
    if (opc[1:0] == 2'b00)      return 2'b10;
    else if (opc[1:0] == 2'b01) return 2'b01;
    else                        return 2'b00;
  endfunction

  // Drive one request and observe 6 cycles. Cycle c is the c-th negedge after the start edge.
  task automatic exec(input row_t r, output obs_t o);
    o.n_write = 0; o.n_read = 0; o.n_done = 0; o.n_fault = 0; o.lat = 0; o.acc_c = 0;
    o.stray = 0; o.addr = 7'd0; o.wdata = 32'd0; o.size = 2'b00; o.sgn = 1'b0;
    @(negedge clk);
    start = 1'b1; is_store = r.st; op = r.op; base = r.base; offset = r.off; store_data = r.data;
    @(negedge clk);
    start = r.restart;
    for (int c = 1; c <= 6; c++) begin
      if (dmem_write || dmem_read) begin
        if (dmem_write) o.n_write++;
        if (dmem_read)  o.n_read++;
        o.acc_c = c; o.addr = dmem_addr; o.wdata = dmem_wdata;
        o.size = {dmem_is_byte, dmem_is_half}; o.sgn = dmem_is_signed;
      end else if (dmem_addr != 7'd0 || dmem_wdata != 32'd0 || dmem_is_byte ||
                   dmem_is_half || dmem_is_signed) begin
        o.stray++;
      end
      if (done)  begin o.n_done++;  if (o.lat == 0) o.lat = c; end
      if (fault) begin o.n_fault++; if (o.lat == 0) o.lat = c; end
      start = r.restart && (c == 1);
      if (c < 6) @(negedge clk);
    end
    start = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    compared++;
    if ({dmem_write, dmem_read, dmem_addr, dmem_wdata, dmem_is_byte, dmem_is_half,
         dmem_is_signed} !== 42'd0) begin
      failed++;
      $display("FAIL reset_dmem: got w=%b r=%b a=%h wd=%h b=%b h=%b s=%b want all 0",
               dmem_write, dmem_read, dmem_addr, dmem_wdata, dmem_is_byte, dmem_is_half,
               dmem_is_signed);
    end
    compared++;
    if ({mdr, busy, done, fault, fault_code, bad_vaddr} !== 69'd0) begin
      failed++;
      $display("FAIL reset_status: got mdr=%h busy=%b done=%b fault=%b code=%b bad=%h want 0",
               mdr, busy, done, fault, fault_code, bad_vaddr);
    end
    rst = 1'b0;
    @(negedge clk);
    compared++;
    if (busy !== 1'b0) begin
      failed++; $display("FAIL reset_idle_busy: got %b want 0", busy);
    end
  endtask

  task automatic test_word_byte();
    row_t t[$]; row_t e; obs_t o; logic [31:0] ea;
    t.push_back(mk(1'b1, 3'b011, 32'h38, 16'h0004, 32'haabbccdd, 1'b0, 1'b0, 32'h0, 2'b00, 32'h0, 1'b0));
    t.push_back(mk(1'b0, 3'b011, 32'h38, 16'h0004, 32'h0, 1'b0, 1'b0, 32'haabbccdd, 2'b00, 32'h0, 1'b1));
    t.push_back(mk(1'b1, 3'b000, 32'h8, 16'h0000, 32'hb1b2b3b4, 1'b0, 1'b0, 32'haabbccdd, 2'b00, 32'h0, 1'b0));
    t.push_back(mk(1'b0, 3'b000, 32'h8, 16'h0000, 32'h0, 1'b0, 1'b0, 32'hffffffb4, 2'b00, 32'h0, 1'b1));
    t.push_back(mk(1'b0, 3'b100, 32'h8, 16'h0000, 32'h0, 1'b0, 1'b0, 32'h000000b4, 2'b00, 32'h0, 1'b0));
    foreach (t[i]) begin
      sb.push_back(t[i]);
      exec(t[i], o);
      e = sb.pop_front();
      ea = e.base + {{16{e.off[15]}}, e.off};
      compared++;
      if (o.n_done !== (e.flt ? 0 : 1) || o.n_fault !== (e.flt ? 1 : 0)) begin
        failed++; $display("FAIL wb[%0d] outcome: got done=%0d fault=%0d want fault=%b", i, o.n_done, o.n_fault, e.flt);
      end
      compared++;
      if (o.lat !== (e.flt ? 2 : 3)) begin
        failed++; $display("FAIL wb[%0d] latency: got %0d want %0d", i, o.lat, e.flt ? 2 : 3);
      end
      compared++;
      if (o.n_write !== ((!e.flt && e.st) ? 1 : 0) || o.n_read !== ((!e.flt && !e.st) ? 1 : 0) || o.stray !== 0) begin
        failed++; $display("FAIL wb[%0d] strobes: got w=%0d r=%0d stray=%0d", i, o.n_write, o.n_read, o.stray);
      end
      compared++;
      if (mdr !== e.mdr) begin
        failed++; $display("FAIL wb[%0d] mdr: got %h want %h", i, mdr, e.mdr);
      end
      if (e.flt) begin
        compared++;
        if (fault_code !== e.code || bad_vaddr !== e.bad) begin
          failed++; $display("FAIL wb[%0d] fault_info: got %b/%h want %b/%h", i, fault_code, bad_vaddr, e.code, e.bad);
        end
      end else begin
        compared++;
        if (o.addr !== ea[6:0] || o.acc_c !== 2 || o.size !== exp_size(e.op) || o.sgn !== e.sgn) begin
          failed++; $display("FAIL wb[%0d] access: got a=%h c=%0d sz=%b s=%b want a=%h c=2 sz=%b s=%b",
                             i, o.addr, o.acc_c, o.size, o.sgn, ea[6:0], exp_size(e.op), e.sgn);
        end
      end
      if (!e.flt && e.st) begin
        compared++;
        if (o.wdata !== e.data) begin
          failed++; $display("FAIL wb[%0d] wdata: got %h want %h", i, o.wdata, e.data);
        end
      end
    end
  endtask

  task automatic test_faults();
    row_t t[$]; row_t e; obs_t o; logic [31:0] ea;
    t.push_back(mk(1'b1, 3'b001, 32'h10, 16'hfffd, 32'h12345678, 1'b0, 1'b1, 32'hb4, 2'b01, 32'h0000000d, 1'b0));
    t.push_back(mk(1'b0, 3'b011, 32'h7c, 16'h0008, 32'h0, 1'b0, 1'b1, 32'hb4, 2'b10, 32'h00000084, 1'b0));
    t.push_back(mk(1'b0, 3'b010, 32'h0, 16'h0000, 32'h0, 1'b0, 1'b1, 32'hb4, 2'b11, 32'h0, 1'b0));
    t.push_back(mk(1'b1, 3'b100, 32'h0, 16'h0004, 32'h5, 1'b0, 1'b1, 32'hb4, 2'b11, 32'h4, 1'b0));
    t.push_back(mk(1'b0, 3'b110, 32'h1, 16'h0000, 32'h0, 1'b0, 1'b1, 32'hb4, 2'b11, 32'h1, 1'b0));
    t.push_back(mk(1'b0, 3'b011, 32'h81, 16'h0000, 32'h0, 1'b0, 1'b1, 32'hb4, 2'b01, 32'h81, 1'b0));
    t.push_back(mk(1'b0, 3'b001, 32'h80, 16'h0000, 32'h0, 1'b0, 1'b1, 32'hb4, 2'b10, 32'h80, 1'b0));
    t.push_back(mk(1'b1, 3'b111, 32'h20, 16'h0000, 32'h0, 1'b0, 1'b1, 32'hb4, 2'b11, 32'h20, 1'b0));
    foreach (t[i]) begin
      sb.push_back(t[i]);
      exec(t[i], o);
      e = sb.pop_front();
      ea = e.base + {{16{e.off[15]}}, e.off};
      compared++;
      if (o.n_done !== (e.flt ? 0 : 1) || o.n_fault !== (e.flt ? 1 : 0)) begin
        failed++; $display("FAIL flt[%0d] outcome: got done=%0d fault=%0d want fault=%b", i, o.n_done, o.n_fault, e.flt);
      end
      compared++;
      if (o.lat !== (e.flt ? 2 : 3)) begin
        failed++; $display("FAIL flt[%0d] latency: got %0d want %0d", i, o.lat, e.flt ? 2 : 3);
      end
      compared++;
      if (o.n_write !== ((!e.flt && e.st) ? 1 : 0) || o.n_read !== ((!e.flt && !e.st) ? 1 : 0) || o.stray !== 0) begin
        failed++; $display("FAIL flt[%0d] strobes: got w=%0d r=%0d stray=%0d", i, o.n_write, o.n_read, o.stray);
      end
      compared++;
      if (mdr !== e.mdr) begin
        failed++; $display("FAIL flt[%0d] mdr: got %h want %h", i, mdr, e.mdr);
      end
      if (e.flt) begin
        compared++;
        if (fault_code !== e.code || bad_vaddr !== e.bad) begin
          failed++; $display("FAIL flt[%0d] fault_info: got %b/%h want %b/%h", i, fault_code, bad_vaddr, e.code, e.bad);
        end
      end else begin
        compared++;
        if (o.addr !== ea[6:0] || o.acc_c !== 2 || o.size !== exp_size(e.op) || o.sgn !== e.sgn) begin
          failed++; $display("FAIL flt[%0d] access: got a=%h c=%0d sz=%b s=%b", i, o.addr, o.acc_c, o.size, o.sgn);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    row_t t[$]; row_t e; obs_t o; logic [31:0] ea;
    t.push_back(mk(1'b1, 3'b001, 32'h14, 16'h0000, 32'h99887766, 1'b1, 1'b0, 32'hb4, 2'b00, 32'h0, 1'b0));
    t.push_back(mk(1'b0, 3'b001, 32'h14, 16'h0000, 32'h0, 1'b1, 1'b0, 32'h00007766, 2'b00, 32'h0, 1'b1));
    t.push_back(mk(1'b1, 3'b011, 32'h7c, 16'h0000, 32'hcafef00d, 1'b0, 1'b0, 32'h00007766, 2'b00, 32'h0, 1'b0));
    t.push_back(mk(1'b0, 3'b011, 32'h7c, 16'h0000, 32'h0, 1'b0, 1'b0, 32'hcafef00d, 2'b00, 32'h0, 1'b1));
    t.push_back(mk(1'b1, 3'b011, 32'hffffffff, 16'h0005, 32'h01020304, 1'b0, 1'b0, 32'hcafef00d, 2'b00, 32'h0, 1'b0));
    t.push_back(mk(1'b0, 3'b101, 32'h0, 16'h0006, 32'h0, 1'b0, 1'b0, 32'h00000102, 2'b00, 32'h0, 1'b0));
    t.push_back(mk(1'b0, 3'b000, 32'h80, 16'hffff, 32'h0, 1'b0, 1'b0, 32'hffffffca, 2'b00, 32'h0, 1'b1));
    foreach (t[i]) begin
      sb.push_back(t[i]);
      exec(t[i], o);
      e = sb.pop_front();
      ea = e.base + {{16{e.off[15]}}, e.off};
      compared++;
      if (o.n_done !== (e.flt ? 0 : 1) || o.n_fault !== (e.flt ? 1 : 0)) begin
        failed++; $display("FAIL b2b[%0d] outcome: got done=%0d fault=%0d want fault=%b", i, o.n_done, o.n_fault, e.flt);
      end
      compared++;
      if (o.lat !== (e.flt ? 2 : 3)) begin
        failed++; $display("FAIL b2b[%0d] latency: got %0d want %0d", i, o.lat, e.flt ? 2 : 3);
      end
      compared++;
      if (o.n_write !== ((!e.flt && e.st) ? 1 : 0) || o.n_read !== ((!e.flt && !e.st) ? 1 : 0) || o.stray !== 0) begin
        failed++; $display("FAIL b2b[%0d] strobes: got w=%0d r=%0d stray=%0d", i, o.n_write, o.n_read, o.stray);
      end
      compared++;
      if (mdr !== e.mdr) begin
        failed++; $display("FAIL b2b[%0d] mdr: got %h want %h", i, mdr, e.mdr);
      end
      compared++;
      if (o.addr !== ea[6:0] || o.acc_c !== 2 || o.size !== exp_size(e.op) || o.sgn !== e.sgn) begin
        failed++; $display("FAIL b2b[%0d] access: got a=%h c=%0d sz=%b s=%b want a=%h sz=%b s=%b",
                           i, o.addr, o.acc_c, o.size, o.sgn, ea[6:0], exp_size(e.op), e.sgn);
      end
      if (e.st) begin
        compared++;
        if (o.wdata !== e.data) begin
          failed++; $display("FAIL b2b[%0d] wdata: got %h want %h", i, o.wdata, e.data);
        end
      end
    end
    compared++;
    if (fault_code !== 2'b11 || bad_vaddr !== 32'h20) begin
      failed++; $display("FAIL fault_hold: got %b/%h want 11/00000020", fault_code, bad_vaddr);
    end
  endtask

  task automatic test_reset_mid_access();
    row_t r; obs_t o;
    r = mk(1'b1, 3'b011, 32'h40, 16'h0000, 32'h11111111, 1'b0, 1'b0, 32'h0, 2'b00, 32'h0, 1'b0);
    exec(r, o);
    compared++;
    if (o.n_done !== 1 || o.n_write !== 1) begin
      failed++; $display("FAIL rst_prestore: got done=%0d w=%0d want 1/1", o.n_done, o.n_write);
    end
    @(negedge clk);
    start = 1'b1; is_store = 1'b1; op = 3'b011; base = 32'h40; offset = 16'h0; store_data = 32'h22222222;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    compared++;
    if (dmem_write !== 1'b1) begin
      failed++; $display("FAIL rst_access_write: got %b want 1", dmem_write);
    end
    #2 rst = 1'b1;
    #1;
    compared++;
    if (dmem_write !== 1'b0 || busy !== 1'b0 || mdr !== 32'h0 || dmem_addr !== 7'd0) begin
      failed++; $display("FAIL rst_async_drop: got w=%b busy=%b mdr=%h a=%h want 0", dmem_write, busy, mdr, dmem_addr);
    end
    @(negedge clk);
    rst = 1'b0;
    r = mk(1'b0, 3'b011, 32'h40, 16'h0000, 32'h0, 1'b0, 1'b0, 32'h11111111, 2'b00, 32'h0, 1'b1);
    sb.push_back(r);
    exec(r, o);
    r = sb.pop_front();
    compared++;
    if (o.n_done !== 1 || mdr !== r.mdr) begin
      failed++; $display("FAIL rst_no_write: got done=%0d mdr=%h want 1/%h", o.n_done, mdr, r.mdr);
    end
  endtask

  initial begin
    test_reset();
    test_word_byte();
    test_faults();
    test_back_to_back();
    test_reset_mid_access();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
    $finish;
  end

endmodule
